// File: rtl/axi_lite_bram_master_if.sv
// AXI-lite channel bundle shared by initiators and targets.
// The clock rides along with the bundle so that both ends can tie
// themselves to the bus clock.
interface axi_lite_channel #(
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 64
) (
   input logic clk
);

   // Write address channel
   logic                      aw_valid;
   logic                      aw_ready;
   logic [ADDR_WIDTH-1:0]     aw_addr;
   logic [2:0]                aw_prot;

   // Write data channel
   logic                      w_valid;
   logic                      w_ready;
   logic [DATA_WIDTH-1:0]     w_data;
   logic [DATA_WIDTH/8-1:0]   w_strb;

   // Write response channel
   logic                      b_valid;
   logic                      b_ready;
   logic [1:0]                b_resp;

   // Read address channel
   logic                      ar_valid;
   logic                      ar_ready;
   logic [ADDR_WIDTH-1:0]     ar_addr;
   logic [2:0]                ar_prot;

   // Read data channel
   logic                      r_valid;
   logic                      r_ready;
   logic [DATA_WIDTH-1:0]     r_data;
   logic [1:0]                r_resp;

   modport master (
      input  clk,
      output aw_valid, aw_addr, aw_prot,
      input  aw_ready,
      output w_valid, w_data, w_strb,
      input  w_ready,
      input  b_valid, b_resp,
      output b_ready,
      output ar_valid, ar_addr, ar_prot,
      input  ar_ready,
      input  r_valid, r_data, r_resp,
      output r_ready
   );

   modport slave (
      input  clk,
      input  aw_valid, aw_addr, aw_prot,
      output aw_ready,
      input  w_valid, w_data, w_strb,
      output w_ready,
      output b_valid, b_resp,
      input  b_ready,
      input  ar_valid, ar_addr, ar_prot,
      output ar_ready,
      output r_valid, r_data, r_resp,
      input  r_ready
   );

endinterface

// File: rtl/axi_lite_bram_master.sv
// BRAM-style native port to AXI-lite master bridge.
// A client issues one word access at a time through en/we/addr/wrdata;
// the bridge stalls it with mem_ready while the AXI transaction is in
// flight and reports read data / error status with one-cycle strobes.
module axi_lite_bram_master #(
   parameter int          DATA_WIDTH      = 64,
   parameter int          BRAM_ADDR_WIDTH = 12,
   parameter logic [63:0] BASE_ADDR       = 64'h0,
   parameter logic [2:0]  PROT            = 3'b000
) (
   input  logic                         clk,
   input  logic                         rstn,
   axi_lite_channel.master              master,
   input  logic                         mem_en,
   input  logic [DATA_WIDTH/8-1:0]      mem_we,
   input  logic [BRAM_ADDR_WIDTH-1:0]   mem_addr,
   input  logic [DATA_WIDTH-1:0]        mem_wrdata,
   output logic [DATA_WIDTH-1:0]        mem_rddata,
   output logic                         mem_ready,
   output logic                         mem_rvalid,
   output logic                         mem_err
);

   localparam int STRB_WIDTH = DATA_WIDTH / 8;
   localparam int ADDR_WIDTH = $bits(master.aw_addr);
   localparam int IF_DATA_WIDTH = $bits(master.w_data);
   localparam int ADDR_LSB = $clog2(STRB_WIDTH);
   localparam logic [ADDR_WIDTH-1:0] BASE = BASE_ADDR[ADDR_WIDTH-1:0];

   // Word addresses shifted up to byte addresses must fit the AXI address bus,
   // and both ends of the data path must agree on the word size.
   if (BRAM_ADDR_WIDTH + ADDR_LSB > ADDR_WIDTH) begin : gAddrTooWide
      $error("axi_lite_bram_master: BRAM_ADDR_WIDTH + log2(DATA_WIDTH/8) exceeds ADDR_WIDTH");
   end
   if (IF_DATA_WIDTH != DATA_WIDTH) begin : gDataWidthMismatch
      $error("axi_lite_bram_master: DATA_WIDTH differs from the interface data width");
   end
   if (DATA_WIDTH < 32) begin : gDataTooNarrow
      $error("axi_lite_bram_master: DATA_WIDTH must be at least 32");
   end

   typedef enum logic [2:0] {
      IDLE,
      WRITE,
      WRESP,
      READ_ADDR,
      READ_DATA
   } state_t;

   state_t                  state_q,   state_d;
   logic [ADDR_WIDTH-1:0]   addr_q,    addr_d;
   logic [DATA_WIDTH-1:0]   wrData_q,  wrData_d;
   logic [STRB_WIDTH-1:0]   strb_q,    strb_d;
   logic                    awValid_q, awValid_d;
   logic                    wValid_q,  wValid_d;
   logic                    awDone_q,  awDone_d;
   logic                    wDone_q,   wDone_d;
   logic                    arValid_q, arValid_d;
   logic [DATA_WIDTH-1:0]   rdData_q,  rdData_d;
   logic                    rValid_q,  rValid_d;
   logic                    err_q,     err_d;

   logic                    awHandshake;
   logic                    wHandshake;
   logic                    unusedBits;

   assign awHandshake = awValid_q & master.aw_ready;
   assign wHandshake  = wValid_q  & master.w_ready;

   // Only the error bit of the response code matters here; the clock
   // carried by the interface is the same net as clk.
   assign unusedBits = ^{master.b_resp[0], master.r_resp[0], master.clk};

   // State and datapath registers; reset aborts any transaction and drops every valid
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q   <= IDLE;
         addr_q    <= '0;
         wrData_q  <= '0;
         strb_q    <= '0;
         awValid_q <= 1'b0;
         wValid_q  <= 1'b0;
         awDone_q  <= 1'b0;
         wDone_q   <= 1'b0;
         arValid_q <= 1'b0;
         rdData_q  <= '0;
         rValid_q  <= 1'b0;
         err_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         addr_q    <= addr_d;
         wrData_q  <= wrData_d;
         strb_q    <= strb_d;
         awValid_q <= awValid_d;
         wValid_q  <= wValid_d;
         awDone_q  <= awDone_d;
         wDone_q   <= wDone_d;
         arValid_q <= arValid_d;
         rdData_q  <= rdData_d;
         rValid_q  <= rValid_d;
         err_q     <= err_d;
      end
   end

   // Next-state logic: capture a request in IDLE, then walk the AXI channels one transaction at a time
   always_comb begin
      state_d   = state_q;
      addr_d    = addr_q;
      wrData_d  = wrData_q;
      strb_d    = strb_q;
      awValid_d = awValid_q;
      wValid_d  = wValid_q;
      awDone_d  = awDone_q;
      wDone_d   = wDone_q;
      arValid_d = arValid_q;
      rdData_d  = rdData_q;
      rValid_d  = 1'b0;
      err_d     = 1'b0;

      unique case (state_q)
         IDLE: begin
            if (mem_en) begin
               addr_d   = BASE + (ADDR_WIDTH'(mem_addr) << ADDR_LSB);
               wrData_d = mem_wrdata;
               strb_d   = mem_we;
               if (|mem_we) begin
                  state_d   = WRITE;
                  awValid_d = 1'b1;
                  wValid_d  = 1'b1;
                  awDone_d  = 1'b0;
                  wDone_d   = 1'b0;
               end else begin
                  state_d   = READ_ADDR;
                  arValid_d = 1'b1;
               end
            end
         end

         WRITE: begin
            if (awHandshake) begin
               awValid_d = 1'b0;
               awDone_d  = 1'b1;
            end
            if (wHandshake) begin
               wValid_d = 1'b0;
               wDone_d  = 1'b1;
            end
            if ((awDone_q | awHandshake) & (wDone_q | wHandshake)) begin
               state_d = WRESP;
            end
         end

         WRESP: begin
            if (master.b_valid) begin
               state_d = IDLE;
               err_d   = master.b_resp[1];
            end
         end

         READ_ADDR: begin
            if (master.ar_ready) begin
               arValid_d = 1'b0;
               state_d   = READ_DATA;
            end
         end

         READ_DATA: begin
            if (master.r_valid) begin
               rdData_d = master.r_data;
               rValid_d = 1'b1;
               err_d    = master.r_resp[1];
               state_d  = IDLE;
            end
         end

         default: begin
            state_d = IDLE;
         end
      endcase
   end

   assign master.aw_valid = awValid_q;
   assign master.aw_addr  = addr_q;
   assign master.aw_prot  = PROT;
   assign master.w_valid  = wValid_q;
   assign master.w_data   = wrData_q;
   assign master.w_strb   = strb_q;
   assign master.b_ready  = (state_q == WRESP);
   assign master.ar_valid = arValid_q;
   assign master.ar_addr  = addr_q;
   assign master.ar_prot  = PROT;
   assign master.r_ready  = (state_q == READ_DATA);

   assign mem_ready  = (state_q == IDLE);
   assign mem_rvalid = rValid_q;
   assign mem_err    = err_q;
   assign mem_rddata = rdData_q;

`ifndef SYNTHESIS
   // A request with unknown byte enables cannot be classified as read or write
   always_ff @(posedge clk) begin
      if (rstn && mem_en) begin
         assert (!$isunknown(mem_we))
            else $error("axi_lite_bram_master: mem_en with unknown mem_we");
      end
   end
`endif

endmodule

// File: tb/tb_axi_lite_bram_master.sv
// Testbench for axi_lite_bram_master: directed scenarios followed by a
// randomized mix of reads and writes against a word-level memory model.
module tb_axi_lite_bram_master;

   localparam int          DW   = 64;
   localparam int          AW   = 32;
   localparam int          BAW  = 12;
   localparam logic [31:0] BASE = 32'h8000_0000;

   logic            clk;
   logic            rstn;
   logic            mem_en;
   logic [7:0]      mem_we;
   logic [BAW-1:0]  mem_addr;
   logic [DW-1:0]   mem_wrdata;
   logic [DW-1:0]   mem_rddata;
   logic            mem_ready;
   logic            mem_rvalid;
   logic            mem_err;

   axi_lite_channel #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus (.clk(clk));

   axi_lite_bram_master #(
      .DATA_WIDTH(DW),
      .BRAM_ADDR_WIDTH(BAW),
      .BASE_ADDR({32'h0, BASE}),
      .PROT(3'b000)
   ) dut (
      .clk(clk),
      .rstn(rstn),
      .master(bus),
      .mem_en(mem_en),
      .mem_we(mem_we),
      .mem_addr(mem_addr),
      .mem_wrdata(mem_wrdata),
      .mem_rddata(mem_rddata),
      .mem_ready(mem_ready),
      .mem_rvalid(mem_rvalid),
      .mem_err(mem_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   // Slave behaviour knobs: *Delay for aw/w/ar is the number of cycles valid is
   // held (1 = immediate ready); bDelay/rDelay are extra wait cycles before valid.
   int         awDelay = 1, wDelay = 1, arDelay = 1, bDelay = 0, rDelay = 0;
   logic [1:0] bResp = 2'b00, rResp = 2'b00;

   // Observation counters
   int awCount = 0, wCount = 0, bCount = 0, arCount = 0, rCount = 0;
   int awHigh = 0, wHigh = 0;
   int bDropped = 0, rDropped = 0;
   int awWait = 0, wWait = 0, arWait = 0, bWait = 0, rWait = 0;
   int rvalidCnt = 0, errCnt = 0, errWithRvalid = 0;
   logic [31:0] lastAwAddr = '0, lastArAddr = '0;
   logic [63:0] lastWData = '0, lastRd = '0;
   logic [7:0]  lastWStrb = '0;

   logic [63:0] slaveMem [logic [31:0]];
   logic [63:0] refMem   [int];

   function automatic logic [63:0] mergeBytes(input logic [63:0] old, input logic [63:0] data,
                                              input logic [7:0] strb);
      logic [63:0] res = old;
      for (int b = 0; b < 8; b++) begin
         if (strb[b]) res[8*b +: 8] = data[8*b +: 8];
      end
      return res;
   endfunction

   function automatic logic [63:0] refRead(input int addr);
      return refMem.exists(addr) ? refMem[addr] : 64'h0;
   endfunction

   // Bus monitor: records handshakes and commits completed writes to slave memory
   always @(posedge clk) begin
      if (rstn) begin
         if (bus.aw_valid) awHigh++;
         if (bus.w_valid) wHigh++;
         if (bus.aw_valid && bus.aw_ready) begin
            awCount++;
            lastAwAddr = bus.aw_addr;
         end
         if (bus.w_valid && bus.w_ready) begin
            wCount++;
            lastWData = bus.w_data;
            lastWStrb = bus.w_strb;
         end
         if (bus.b_valid && bus.b_ready) begin
            bCount++;
            slaveMem[lastAwAddr] = mergeBytes(slaveMem.exists(lastAwAddr) ? slaveMem[lastAwAddr] : 64'h0,
                                              lastWData, lastWStrb);
         end
         if (bus.ar_valid && bus.ar_ready) begin
            arCount++;
            lastArAddr = bus.ar_addr;
         end
         if (bus.r_valid && bus.r_ready) rCount++;
      end
   end

   // Slave driver: updates ready/valid on the falling edge
   always @(negedge clk) begin
      if (!rstn) begin
         bus.aw_ready = 1'b0; bus.w_ready = 1'b0; bus.ar_ready = 1'b0;
         bus.b_valid  = 1'b0; bus.r_valid = 1'b0;
         awWait = 0; wWait = 0; arWait = 0; bWait = 0; rWait = 0;
         bDropped = awCount - bCount;
         rDropped = arCount - rCount;
      end else begin
         if (bus.aw_valid) begin bus.aw_ready = (awWait + 1 >= awDelay); awWait++; end
         else begin bus.aw_ready = 1'b0; awWait = 0; end
         if (bus.w_valid) begin bus.w_ready = (wWait + 1 >= wDelay); wWait++; end
         else begin bus.w_ready = 1'b0; wWait = 0; end
         if (bus.ar_valid) begin bus.ar_ready = (arWait + 1 >= arDelay); arWait++; end
         else begin bus.ar_ready = 1'b0; arWait = 0; end
         if ((awCount - bCount - bDropped > 0) && (wCount - bCount - bDropped > 0)) begin
            bus.b_valid = (bWait >= bDelay); bWait++;
         end else begin
            bus.b_valid = 1'b0; bWait = 0;
         end
         bus.b_resp = bResp;
         if (arCount - rCount - rDropped > 0) begin
            bus.r_valid = (rWait >= rDelay); rWait++;
         end else begin
            bus.r_valid = 1'b0; rWait = 0;
         end
         bus.r_data = slaveMem.exists(lastArAddr) ? slaveMem[lastArAddr] : 64'h0;
         bus.r_resp = rResp;
      end
   end

   // Native-side monitor: counts completion strobes
   always @(negedge clk) begin
      if (rstn) begin
         if (mem_rvalid) begin rvalidCnt++; lastRd = mem_rddata; end
         if (mem_err) errCnt++;
         if (mem_err && mem_rvalid) errWithRvalid++;
      end
   end

   initial begin
      #400000;
      $display("[TB] FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "[TB] simulation time limit reached");
   end

   task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic waitReady(input string tag, output int busy);
      int timedOut = 1;
      busy = 0;
      for (int i = 0; i < 200; i++) begin
         if (mem_ready) begin timedOut = 0; break; end
         busy++;
         @(negedge clk);
      end
      checkOutput(tag, 64'(timedOut), 64'd0);
      #1;
   endtask

   // Issue one native request and wait for the bridge to become ready again
   task automatic applyStimulus(input logic [7:0] we, input logic [BAW-1:0] addr,
                                input logic [63:0] data, output int busy);
      int dummy;
      waitReady("readyBeforeReq", dummy);
      mem_en = 1'b1; mem_we = we; mem_addr = addr; mem_wrdata = data;
      @(negedge clk);
      mem_en = 1'b0; mem_we = '0;
      waitReady("reqTimeout", busy);
      if (we != 0) refMem[int'(addr)] = mergeBytes(refRead(int'(addr)), data, we);
   endtask

   task automatic runWrite(input logic [BAW-1:0] addr, input logic [63:0] data, input logic [7:0] we);
      int busy, b0, e0, expBusy;
      b0 = bCount; e0 = errCnt;
      expBusy = ((awDelay > wDelay) ? awDelay : wDelay) + bDelay + 1;
      applyStimulus(we, addr, data, busy);
      checkOutput("wrAwAddr", 64'(lastAwAddr), 64'(BASE + 32'(addr) * 8));
      checkOutput("wrStrb", 64'(lastWStrb), 64'(we));
      checkOutput("wrData", lastWData, data);
      checkOutput("wrBusy", 64'(busy), 64'(expBusy));
      checkOutput("wrBCount", 64'(bCount - b0), 64'd1);
      checkOutput("wrErr", 64'(errCnt - e0), 64'(bResp[1]));
   endtask

   task automatic runRead(input logic [BAW-1:0] addr);
      int busy, v0, e0;
      v0 = rvalidCnt; e0 = errCnt;
      applyStimulus(8'h00, addr, 64'h0, busy);
      checkOutput("rdArAddr", 64'(lastArAddr), 64'(BASE + 32'(addr) * 8));
      checkOutput("rdBusy", 64'(busy), 64'(arDelay + rDelay + 1));
      checkOutput("rdPulses", 64'(rvalidCnt - v0), 64'd1);
      checkOutput("rdData", lastRd, refRead(int'(addr)));
      checkOutput("rdErr", 64'(errCnt - e0), 64'(rResp[1]));
   endtask

   initial begin
      int a0, v0, e0, ev0, hAw, hW, busy;
      rstn = 1'b0; mem_en = 1'b0; mem_we = '0; mem_addr = '0; mem_wrdata = '0;
      bus.aw_ready = 1'b0; bus.w_ready = 1'b0; bus.ar_ready = 1'b0;
      bus.b_valid = 1'b0; bus.r_valid = 1'b0; bus.b_resp = '0; bus.r_resp = '0; bus.r_data = '0;
      repeat (3) @(negedge clk);

      $display("[TB] reset values");
      checkOutput("rstReady", 64'(mem_ready), 64'd1);
      checkOutput("rstRvalid", 64'(mem_rvalid), 64'd0);
      checkOutput("rstErr", 64'(mem_err), 64'd0);
      checkOutput("rstRdData", mem_rddata, 64'd0);
      checkOutput("rstValids", 64'({bus.aw_valid, bus.w_valid, bus.ar_valid}), 64'd0);
      checkOutput("rstReadies", 64'({bus.b_ready, bus.r_ready}), 64'd0);
      @(posedge clk); #2 rstn = 1'b1;
      @(negedge clk);

      $display("[TB] zero-wait full write");
      runWrite(12'd3, 64'hDEAD_BEEF_0123_4567, 8'hFF);

      $display("[TB] delayed aw_ready");
      awDelay = 4; wDelay = 1;
      hAw = awHigh; hW = wHigh;
      runWrite(12'd4, 64'h0BAD_F00D_CAFE_1234, 8'h0F);
      checkOutput("awValidCycles", 64'(awHigh - hAw), 64'd4);
      checkOutput("wValidCycles", 64'(wHigh - hW), 64'd1);
      awDelay = 1;

      $display("[TB] read with two wait cycles");
      runWrite(12'd5, 64'h1122_3344_5566_7788, 8'hFF);
      rDelay = 2;
      runRead(12'd5);
      rDelay = 0;
      repeat (4) @(negedge clk);
      checkOutput("rdDataHeld", mem_rddata, 64'h1122_3344_5566_7788);

      $display("[TB] error responses");
      bResp = 2'b10;
      runWrite(12'd6, 64'h5555_AAAA_5555_AAAA, 8'hF0);
      bResp = 2'b00; rResp = 2'b11;
      ev0 = errWithRvalid;
      runRead(12'd6);
      checkOutput("rdErrWithRvalid", 64'(errWithRvalid - ev0), 64'd1);
      rResp = 2'b00;

      $display("[TB] mem_en held through a read");
      runWrite(12'd7, 64'h7777_0000_1234_5678, 8'hFF);
      a0 = arCount; v0 = rvalidCnt;
      mem_en = 1'b1; mem_we = 8'h00; mem_addr = 12'd7;
      @(negedge clk);
      waitReady("holdFirst", busy);
      checkOutput("holdOneAr", 64'(arCount - a0), 64'd1);
      checkOutput("holdOnePulse", 64'(rvalidCnt - v0), 64'd1);
      @(negedge clk);
      checkOutput("holdSecondAccepted", 64'(mem_ready), 64'd0);
      mem_en = 1'b0;
      waitReady("holdSecond", busy);
      checkOutput("holdTwoAr", 64'(arCount - a0), 64'd2);
      checkOutput("holdData", lastRd, refRead(7));

      $display("[TB] reset during read data phase");
      rDelay = 10;
      v0 = rvalidCnt;
      mem_en = 1'b1; mem_we = 8'h00; mem_addr = 12'd3;
      @(negedge clk);
      mem_en = 1'b0;
      for (int i = 0; i < 20 && !bus.r_ready; i++) @(negedge clk);
      checkOutput("abortInReadData", 64'(bus.r_ready), 64'd1);
      #2 rstn = 1'b0;
      #1;
      checkOutput("abortArValid", 64'(bus.ar_valid), 64'd0);
      checkOutput("abortRReady", 64'(bus.r_ready), 64'd0);
      checkOutput("abortReady", 64'(mem_ready), 64'd1);
      repeat (2) @(negedge clk);
      @(posedge clk); #2 rstn = 1'b1;
      @(negedge clk);
      checkOutput("abortNoPulse", 64'(rvalidCnt - v0), 64'd0);
      rDelay = 0;
      runRead(12'd3);

      $display("[TB] randomized traffic");
      for (int n = 0; n < 40; n++) begin
         logic [BAW-1:0] addr;
         addr    = BAW'($urandom_range(0, 15));
         awDelay = $urandom_range(1, 3);
         wDelay  = $urandom_range(1, 3);
         arDelay = $urandom_range(1, 3);
         bDelay  = $urandom_range(0, 2);
         rDelay  = $urandom_range(0, 2);
         if ($urandom_range(0, 1) == 1)
            runWrite(addr, {$urandom, $urandom}, 8'($urandom_range(1, 255)));
         else
            runRead(addr);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
